// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron: sequencer state encoding and the
// datapath setup-register selector codes.
package lif_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LD_W,
        LD_TH,
        LD_SH,
        LD_BN,
        LD_IN,
        EXEC,
        SAMPLE,
        FIN
    } state_t;

    localparam logic [2:0] CTRL_INPUTS    = 3'b000;
    localparam logic [2:0] CTRL_WEIGHTS   = 3'b001;
    localparam logic [2:0] CTRL_THRESHOLD = 3'b010;
    localparam logic [2:0] CTRL_SHIFT     = 3'b100;
    localparam logic [2:0] CTRL_BATCHNORM = 3'b110;

    // Setup register targeted by a byte accepted in the given load state.
    function automatic logic [2:0] ctrl_code(input state_t s);
        case (s)
            LD_W:    ctrl_code = CTRL_WEIGHTS;
            LD_TH:   ctrl_code = CTRL_THRESHOLD;
            LD_SH:   ctrl_code = CTRL_SHIFT;
            LD_BN:   ctrl_code = CTRL_BATCHNORM;
            default: ctrl_code = CTRL_INPUTS;
        endcase
    endfunction

endpackage

// File: rtl/lif_sequencer_byte_counter.sv
// Loadable down-counter tracking the bytes still expected in a load state;
// last flags the final byte so the sequencer can advance on its acceptance.
module byte_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             decrement,
    output logic             last
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (decrement && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == WIDTH'(1));

endmodule

// File: rtl/lif_sequencer.sv
// Run sequencer for a LIF neuron: streams configuration and per-step input
// bytes into the datapath, pulses execute per timestep and counts spikes.
module lif_sequencer
    import lif_pkg::*;
#(
    parameter int N_STAGES = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       keep_cfg,
    input  logic [7:0] n_steps,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] dp_data,
    output logic [2:0] dp_ctrl,
    output logic       dp_load,
    output logic       dp_execute,
    input  logic       spike_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] spike_count
);

    localparam int INPUT_BYTES = (2 ** N_STAGES) / 8;
    localparam int CNT_W       = $clog2(INPUT_BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(INPUT_BYTES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [7:0]       steps;
    logic             accept;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             byte_last;

    byte_counter #(.WIDTH(CNT_W)) u_byte_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_value),
        .decrement  (accept),
        .last       (byte_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!keep_cfg)         state_next = LD_W;
                    else if (n_steps == 0) state_next = FIN;
                    else                   state_next = LD_IN;
                end
            end
            LD_W: begin
                in_ready = 1'b1;
                if (in_valid && byte_last) state_next = LD_TH;
            end
            LD_TH: begin
                in_ready = 1'b1;
                if (in_valid && byte_last) state_next = LD_SH;
            end
            LD_SH: begin
                in_ready = 1'b1;
                if (in_valid && byte_last) state_next = LD_BN;
            end
            LD_BN: begin
                in_ready = 1'b1;
                if (in_valid && byte_last) state_next = (steps == 0) ? FIN : LD_IN;
            end
            LD_IN: begin
                in_ready = 1'b1;
                if (in_valid && byte_last) state_next = EXEC;
            end
            EXEC:    state_next = SAMPLE;
            // steps still holds the count including the step being sampled now
            SAMPLE:  state_next = (steps > 8'd1) ? LD_IN : FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign accept    = in_ready && in_valid;
    assign cnt_load  = (state_next != state);
    assign cnt_value = (state_next == LD_W || state_next == LD_IN) ? CNT_FULL : CNT_ONE;
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);

    // Registered datapath strobes: execute trails the last input load by a
    // cycle, so load and execute can never coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            dp_load     <= 1'b0;
            dp_execute  <= 1'b0;
            dp_data     <= '0;
            dp_ctrl     <= '0;
            steps       <= '0;
            spike_count <= '0;
        end else begin
            dp_load    <= accept;
            dp_execute <= (state == EXEC);
            if (accept) begin
                dp_data <= in_data;
                dp_ctrl <= ctrl_code(state);
            end
            if (state == IDLE && start) begin
                steps       <= n_steps;
                spike_count <= '0;
            end
            if (state == SAMPLE) begin
                steps <= steps - 8'd1;
                if (spike_in && spike_count != 8'hFF) spike_count <= spike_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lif_sequencer.sv
// Randomized self-checking bench for lif_sequencer against a byte/event-level
// reference model of a run.
module tb_lif_sequencer;

    localparam int NS = 5;
    localparam int IB = (2 ** NS) / 8;

    logic       clk = 1'b0;
    logic       reset, start, keep_cfg, in_valid, spike_in;
    logic [7:0] n_steps, in_data;
    logic       in_ready, dp_load, dp_execute, busy, done;
    logic [7:0] dp_data, spike_count;
    logic [2:0] dp_ctrl;

    lif_sequencer #(.N_STAGES(NS)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .keep_cfg    (keep_cfg),
        .n_steps     (n_steps),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .dp_data     (dp_data),
        .dp_ctrl     (dp_ctrl),
        .dp_load     (dp_load),
        .dp_execute  (dp_execute),
        .spike_in    (spike_in),
        .busy        (busy),
        .done        (done),
        .spike_count (spike_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [2:0] exp_ctrl[$];
    bit         exp_exec[$];
    logic [7:0] exp_bytes[$];
    logic [2:0] ev_ctrl[$];
    logic [7:0] ev_data[$];
    bit         ev_exec[$];

    int  done_seen, overlap, load_err, seq_err, model_spikes, done_cyc, in_loads;
    int  sc_at_done;
    bit  aborted;

    // Reference: expected ordered list of datapath events for one run.
    task automatic build_expected(input bit keep, input int n);
        exp_ctrl.delete();
        exp_exec.delete();
        if (!keep) begin
            for (int i = 0; i < IB; i++) begin exp_ctrl.push_back(3'b001); exp_exec.push_back(1'b0); end
            exp_ctrl.push_back(3'b010); exp_exec.push_back(1'b0);
            exp_ctrl.push_back(3'b100); exp_exec.push_back(1'b0);
            exp_ctrl.push_back(3'b110); exp_exec.push_back(1'b0);
        end
        for (int s = 0; s < n; s++) begin
            for (int i = 0; i < IB; i++) begin exp_ctrl.push_back(3'b000); exp_exec.push_back(1'b0); end
            exp_ctrl.push_back(3'b000); exp_exec.push_back(1'b1);
        end
    endtask

    // Runs one start..done sequence; vmode 0 valid held, 1 toggling, 2 random;
    // smode 0/1 constant spike level in SAMPLE, 2 random.
    task automatic drive_run(input bit keep, input int n, input int vmode, input int smode,
                             input bit pester, input int abort_at);
        logic [7:0] tx[$];
        bit acc_prev;
        int cyc, total, li;
        bit fin;
        ev_ctrl.delete(); ev_data.delete(); ev_exec.delete(); exp_bytes.delete();
        done_seen = 0; overlap = 0; load_err = 0; seq_err = 0; model_spikes = 0;
        done_cyc = -1; in_loads = 0; aborted = 0; sc_at_done = -1;
        total = (keep ? 0 : IB + 3) + n * IB;
        for (int i = 0; i < total; i++) tx.push_back(8'($urandom_range(0, 255)));
        exp_bytes = tx;
        build_expected(keep, n);
        @(negedge clk);
        start = 1'b1; keep_cfg = keep; n_steps = 8'(n); in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; keep_cfg = 1'($urandom_range(0, 1)); n_steps = 8'($urandom_range(0, 255));
        acc_prev = 1'b0; cyc = 0; fin = 1'b0;
        while (!fin && !aborted && cyc < 20000) begin
            if (dp_load && dp_execute) overlap++;
            if (dp_load !== acc_prev) load_err++;
            if (dp_load) begin
                ev_ctrl.push_back(dp_ctrl); ev_data.push_back(dp_data); ev_exec.push_back(1'b0);
                if (dp_ctrl == 3'b000) in_loads++;
            end
            if (dp_execute) begin
                ev_ctrl.push_back(3'b000); ev_data.push_back(8'h00); ev_exec.push_back(1'b1);
                spike_in = (smode == 2) ? 1'($urandom_range(0, 1)) : (smode == 1);
                model_spikes += int'(spike_in);
            end else begin
                spike_in = 1'($urandom_range(0, 1));
            end
            if (done) begin
                done_seen++; fin = 1'b1; done_cyc = cyc; sc_at_done = int'(spike_count);
            end
            if (abort_at >= 0 && in_loads == abort_at) aborted = 1'b1;
            if (!fin && !aborted) begin
                case (vmode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = cyc[0];
                    default: in_valid = 1'($urandom_range(0, 1));
                endcase
                in_data  = (tx.size() > 0) ? tx[0] : 8'($urandom_range(0, 255));
                acc_prev = in_valid && in_ready;
                if (acc_prev && tx.size() > 0) void'(tx.pop_front());
                start = pester && (cyc == 5 || cyc == 9);
                if (start) begin keep_cfg = ~keep; n_steps = 8'(n + 7); end
                @(negedge clk);
                cyc++;
            end
        end
        in_valid = 1'b0; start = 1'b0; spike_in = 1'b0;
        if (!aborted) begin
            li = 0;
            if (ev_exec.size() != exp_exec.size()) seq_err++;
            for (int i = 0; i < ev_exec.size() && i < exp_exec.size(); i++) begin
                if (ev_exec[i] != exp_exec[i]) seq_err++;
                else if (!ev_exec[i]) begin
                    if (ev_ctrl[i] !== exp_ctrl[i] || ev_data[i] !== exp_bytes[li]) seq_err++;
                    li++;
                end
            end
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; keep_cfg = 1'b0; n_steps = '0;
        in_valid = 1'b0; in_data = '0; spike_in = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, in_ready, dp_load, dp_execute} !== 5'b0)
            $display("FAIL reset_ctrl got=%b want=00000", {busy, done, in_ready, dp_load, dp_execute});
        else n_pass++;
        n_checks++;
        if ({dp_data, dp_ctrl, spike_count} !== 19'b0)
            $display("FAIL reset_data got=%h/%b/%0d want=0", dp_data, dp_ctrl, spike_count);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic check_run(input string tag, input int want_spikes);
        n_checks++;
        if (done_seen !== 1) $display("FAIL %s_done got=%0d want=1", tag, done_seen); else n_pass++;
        n_checks++;
        if (seq_err !== 0) $display("FAIL %s_seq got=%0d events (%0d errs) want=%0d", tag, ev_exec.size(), seq_err, exp_exec.size());
        else n_pass++;
        n_checks++;
        if (overlap !== 0 || load_err !== 0) $display("FAIL %s_strobes got overlap=%0d stray=%0d want=0", tag, overlap, load_err);
        else n_pass++;
        n_checks++;
        if (sc_at_done !== want_spikes) $display("FAIL %s_spikes got=%0d want=%0d", tag, sc_at_done, want_spikes);
        else n_pass++;
    endtask

    task automatic test_config_run();
        drive_run(1'b0, 2, 0, 2, 1'b0, -1);
        check_run("cfg_run", sat(model_spikes));
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL cfg_idle got busy=%b done=%b want=0/0", busy, done);
        else n_pass++;
    endtask

    task automatic test_stall();
        drive_run(1'b0, 2, 1, 2, 1'b0, -1);
        check_run("stall_toggle", sat(model_spikes));
        drive_run(1'b0, int'($urandom_range(1, 6)), 2, 2, 1'b0, -1);
        check_run("stall_random", sat(model_spikes));
    endtask

    task automatic test_saturate();
        drive_run(1'b0, 255, 0, 1, 1'b0, -1);
        check_run("sat255", 255);
        repeat (3) @(negedge clk);
        n_checks++;
        if (spike_count !== 8'd255) $display("FAIL sat_hold got=%0d want=255", spike_count); else n_pass++;
        drive_run(1'b1, 3, 2, 1, 1'b0, -1);
        check_run("sat_rerun", 3);
    endtask

    task automatic test_zero_steps();
        drive_run(1'b1, 0, 0, 2, 1'b0, -1);
        check_run("zero_keep", 0);
        n_checks++;
        if (done_cyc < 0 || done_cyc > 1) $display("FAIL zero_keep_latency got=%0d want<=1", done_cyc); else n_pass++;
        drive_run(1'b0, 0, 2, 2, 1'b0, -1);
        check_run("zero_cfg", 0);
    endtask

    task automatic test_reset_mid();
        int act;
        drive_run(1'b0, 3, 0, 2, 1'b0, 1);
        n_checks++;
        if (aborted !== 1'b1) $display("FAIL abort_reach got=%b want=1", aborted); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done, in_ready, dp_load, dp_execute, dp_data, dp_ctrl, spike_count} !== 24'b0)
            $display("FAIL abort_outputs got=%b want=0", {busy, done, in_ready, dp_load, dp_execute, dp_data, dp_ctrl, spike_count});
        else n_pass++;
        reset = 1'b0;
        act = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            act += int'(done) + int'(dp_load) + int'(dp_execute) + int'(busy);
        end
        in_valid = 1'b0;
        n_checks++;
        if (act !== 0) $display("FAIL abort_quiet got=%0d want=0", act); else n_pass++;
        drive_run(1'b0, 1, 2, 2, 1'b0, -1);
        check_run("after_abort", sat(model_spikes));
    endtask

    task automatic test_start_busy();
        drive_run(1'b0, 3, 0, 2, 1'b1, -1);
        check_run("start_busy", sat(model_spikes));
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            drive_run(1'($urandom_range(0, 1)), int'($urandom_range(0, 8)), 2, 2, 1'($urandom_range(0, 1)), -1);
            check_run($sformatf("rand%0d", r), sat(model_spikes));
        end
    endtask

    initial begin
        test_reset();
        test_config_run();
        test_stall();
        test_saturate();
        test_zero_steps();
        test_reset_mid();
        test_start_busy();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
